sha256_compress: RTL

SHA-256 compression core sitting directly downstream of the message expansion stage. It consumes one expanded word W_t per clock for 64 consecutive cycles, runs the 64 compression rounds against the internal K constant ROM, and adds the result into the 256-bit chaining state H. It also drives the expansion stage's select and flags the cycles in which upstream logic must present an original message word.

---
 rtl/sha256_compress.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sha256_compress.sv
// sha256_compress
//   SHA-256 compression core. Consumes one expanded message word W_t per
//   clock for 64 back-to-back rounds, then folds the working variables into
//   the 256-bit chaining state H. Also drives the expansion stage's select
//   and flags the cycles in which upstream must present an original word.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (aborts any block, H := IV)
//   start     begin one block (sampled only in IDLE)
//   init      with start: 1 = first block (H := IV), 0 = chain from H
//   w_in      W_t from the expansion stage, valid in round cycle t
//   exp_sel   0 = expansion stage passes original word, 1 = expanded word
//   word_req  upstream must drive message word W_t (t = 0..15)
//   busy      block in progress (ROUND/FINAL/DONE)
//   done      one-cycle pulse, digest valid from this cycle
//   digest    H0..H7, H0 in [255:224]
module sha256_compress (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init,
  input  logic [31:0]  w_in,
  output logic         exp_sel,
  output logic         word_req,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state_reg, state_next;
  logic [5:0]  t_reg, t_next;
  // Working variables a..h live in wv[0]..wv[7].
  logic [31:0] wv_reg [8];
  logic [31:0] wv_next [8];
  logic [31:0] h_reg [8];
  logic [31:0] h_next [8];
  logic [31:0] fin_sum [8];

  logic [31:0] big_s0, big_s1, ch, maj, k_t, t1, t2;

  // Round datapath (only meaningful in ROUND, harmless otherwise).
  always_comb begin
    k_t    = K_ROM[t_reg];
    big_s1 = rotr(wv_reg[4], 6) ^ rotr(wv_reg[4], 11) ^ rotr(wv_reg[4], 25);
    ch     = (wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]);
    big_s0 = rotr(wv_reg[0], 2) ^ rotr(wv_reg[0], 13) ^ rotr(wv_reg[0], 22);
    maj    = (wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]);
    t1     = wv_reg[7] + big_s1 + ch + k_t + w_in;
    t2     = big_s0 + maj;
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_h
      assign fin_sum[gi] = h_reg[gi] + wv_reg[gi];
      assign digest[255 - 32*gi -: 32] = h_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    wv_next    = wv_reg;
    h_next     = h_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ROUND;
          t_next     = 6'd0;
          for (int i = 0; i < 8; i++) begin
            wv_next[i] = init ? IV[i] : h_reg[i];
            if (init) h_next[i] = IV[i];
          end
        end
      end
      ROUND: begin
        wv_next[0] = t1 + t2;
        wv_next[1] = wv_reg[0];
        wv_next[2] = wv_reg[1];
        wv_next[3] = wv_reg[2];
        wv_next[4] = wv_reg[3] + t1;
        wv_next[5] = wv_reg[4];
        wv_next[6] = wv_reg[5];
        wv_next[7] = wv_reg[6];
        // 6-bit counter wraps back to 0 after round 63.
        t_next = t_reg + 6'd1;
        if (t_reg == 6'd63) state_next = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) h_next[i] = fin_sum[i];
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      t_reg     <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        wv_reg[i] <= 32'd0;
        h_reg[i]  <= IV[i];
      end
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      wv_reg    <= wv_next;
      h_reg     <= h_next;
    end
  end

  // Original words for rounds 0..15, expanded words for 16..63.
  assign word_req = (state_reg == ROUND) && (t_reg[5:4] == 2'b00);
  assign exp_sel  = (state_reg == ROUND) && (t_reg[5:4] != 2'b00);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);

endmodule
